// File: rtl/tlb_array.sv
// Fully-associative joint TLB (paired even/odd pages): fetch search port, CP0 read/write port, TLBP probe engine.
// Optional: define TLB_PERF_CNT_EN to add s0_lookup_valid / s0_miss_cnt (s0 miss counter).
module tlb_array #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [18:0]     s0_vpn2,
    input  logic            s0_odd_page,
    input  logic [7:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_pfn,
    output logic [2:0]      s0_c,
    output logic            s0_d,
    output logic            s0_v,
`ifdef TLB_PERF_CNT_EN
    input  logic            s0_lookup_valid,
    output logic [31:0]     s0_miss_cnt,
`endif
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic [77:0]     w_entry,
    input  logic [IDXW-1:0] r_index,
    output logic [77:0]     r_entry,
    input  logic            p_req,
    input  logic [18:0]     p_vpn2,
    input  logic [7:0]      p_asid,
    output logic            p_ready,
    output logic            p_done,
    output logic            p_found,
    output logic [IDXW-1:0] p_index
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_LOOKUP,
        P_DONE
    } probe_state_t;

    tlb_entry_t        tlb_mem [TLBNUM];
    logic [TLBNUM-1:0] s0_match;
    logic [TLBNUM-1:0] p_match;
    tlb_entry_t        s0_sel;
    logic [18:0]       key_vpn2;
    logic [7:0]        key_asid;
    probe_state_t      p_state;
    probe_state_t      p_state_nxt;
    logic              p_accept;

    // Lowest matching index wins so duplicate entries resolve deterministically.
    function automatic logic [IDXW:0] first_hit(input logic [TLBNUM-1:0] match);
        logic [IDXW:0] res;
        res = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (match[i] && !res[IDXW]) begin
                res = {1'b1, IDXW'(i)};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                tlb_mem[i] <= '0;
            end
        end else if (we) begin
            tlb_mem[w_index] <= tlb_entry_t'(w_entry);
        end
    end

    assign r_entry = tlb_mem[r_index];

    always_comb begin
        s0_match = '0;
        p_match  = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            s0_match[i] = (tlb_mem[i].vpn2 == s0_vpn2) &&
                          (tlb_mem[i].g || (tlb_mem[i].asid == s0_asid));
            p_match[i]  = (tlb_mem[i].vpn2 == key_vpn2) &&
                          (tlb_mem[i].g || (tlb_mem[i].asid == key_asid));
        end
    end

    always_comb begin
        {s0_found, s0_index} = first_hit(s0_match);
        s0_sel = tlb_mem[s0_index];
        s0_pfn = '0;
        s0_c   = '0;
        s0_d   = 1'b0;
        s0_v   = 1'b0;
        if (s0_found) begin
            s0_pfn = s0_odd_page ? s0_sel.pfn1 : s0_sel.pfn0;
            s0_c   = s0_odd_page ? s0_sel.c1   : s0_sel.c0;
            s0_d   = s0_odd_page ? s0_sel.d1   : s0_sel.d0;
            s0_v   = s0_odd_page ? s0_sel.v1   : s0_sel.v0;
        end
    end

`ifdef TLB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_miss_cnt <= '0;
        end else if (s0_lookup_valid && !s0_found) begin
            s0_miss_cnt <= s0_miss_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        p_state_nxt = p_state;
        p_ready     = 1'b0;
        p_done      = 1'b0;
        p_accept    = 1'b0;
        case (p_state)
            P_IDLE: begin
                p_ready = 1'b1;
                if (p_req) begin
                    p_accept    = 1'b1;
                    p_state_nxt = P_LOOKUP;
                end
            end
            P_LOOKUP: p_state_nxt = P_DONE;
            P_DONE: begin
                p_done      = 1'b1;
                p_state_nxt = P_IDLE;
            end
            default: p_state_nxt = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state  <= P_IDLE;
            key_vpn2 <= '0;
            key_asid <= '0;
            p_found  <= 1'b0;
            p_index  <= '0;
        end else begin
            p_state <= p_state_nxt;
            if (p_accept) begin
                key_vpn2 <= p_vpn2;
                key_asid <= p_asid;
            end
            // Result registers only move on LOOKUP, so they hold until the next probe completes.
            if (p_state == P_LOOKUP) begin
                {p_found, p_index} <= first_hit(p_match);
            end
        end
    end

endmodule
